// File: rtl/joy_serial_scanner.sv
// Serial joystick/button scanner for a chain of 74HC165-style PISO shift
// registers: drives shift clock and load strobe, deserialises one frame per
// pass and debounces it into a stable, active-low button vector.
module joy_serial_scanner #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 8,
  parameter int CLK_DIV_LOG2    = 8,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int INVERT          = 0
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   scan_en,
  input  logic                                   joy_data,
  output logic                                   joy_clk,
  output logic                                   joy_load_n,
  output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] buttons,
  output logic                                   frame_valid,
  output logic                                   changed
);

  localparam int TOTAL = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic             INV_BIT  = (INVERT != 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

  logic [CLK_DIV_LOG2-1:0] prescaler_q;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  // The final bit of a frame goes straight into frame_word, so the shadow
  // only needs to hold the first TOTAL-1 samples.
  logic [TOTAL-2:0]        shadow_q, shadow_d;
  logic [TOTAL-1:0]        last_q, last_d;
  logic [TOTAL-1:0]        buttons_q, buttons_d;
  logic [CNT_W-1:0]        stable_q, stable_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    changed_q, changed_d;

  logic             tick;
  logic             sample;
  logic [TOTAL-1:0] frame_word;

  assign tick       = (prescaler_q == '0);
  assign sample     = joy_data ^ INV_BIT;
  assign frame_word = {sample, shadow_q};

  assign joy_clk     = prescaler_q[CLK_DIV_LOG2-1];
  assign joy_load_n  = (bit_idx_q != '0);
  assign buttons     = buttons_q;
  assign frame_valid = frame_valid_q;
  assign changed     = changed_q;

  // Free-running prescaler; wraps and sets the shift-tick cadence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prescaler_q <= '0;
    else          prescaler_q <= prescaler_q + 1'b1;
  end

  // Per-tick sampling, frame commit and debounce decision.
  always_comb begin
    bit_idx_d     = bit_idx_q;
    shadow_d      = shadow_q;
    last_d        = last_q;
    buttons_d     = buttons_q;
    stable_d      = stable_q;
    frame_valid_d = 1'b0;
    changed_d     = 1'b0;
    // scan_en only gates the start of a frame; a frame in progress finishes.
    if (tick && ((bit_idx_q != '0) || scan_en)) begin
      for (int i = 0; i < TOTAL - 1; i++) begin
        if (bit_idx_q == IDX_W'(i)) shadow_d[i] = sample;
      end
      if (bit_idx_q == LAST_IDX) begin
        bit_idx_d     = '0;
        frame_valid_d = 1'b1;
        last_d        = frame_word;
        if (frame_word == last_q) begin
          stable_d = (stable_q == CNT_MAX) ? stable_q : stable_q + 1'b1;
        end else begin
          stable_d = CNT_W'(1);
        end
        if ((stable_d == CNT_MAX) && (frame_word != buttons_q)) begin
          buttons_d = frame_word;
          changed_d = 1'b1;
        end
      end else begin
        bit_idx_d = bit_idx_q + 1'b1;
      end
    end
  end

  // Scanner state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx_q     <= '0;
      shadow_q      <= '1;
      last_q        <= '1;
      buttons_q     <= '1;
      stable_q      <= '0;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;
    end else begin
      bit_idx_q     <= bit_idx_d;
      shadow_q      <= shadow_d;
      last_q        <= last_d;
      buttons_q     <= buttons_d;
      stable_q      <= stable_d;
      frame_valid_q <= frame_valid_d;
      changed_q     <= changed_d;
    end
  end

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Bench for joy_serial_scanner: three instances (default-style 2x8 with
// debounce 2, 3x12 without debounce, inverted 2x8) each fed by a behavioural
// 74HC165 chain model; a frame-level debounce model supplies expectations.
module tb_joy_serial_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic scan_en_a = 1'b1, scan_en_b = 1'b1, scan_en_c = 1'b1;

  logic        jclk_a, load_a, fv_a, chg_a, data_a;
  logic [15:0] btn_a;
  logic        jclk_b, load_b, fv_b, chg_b, data_b;
  logic [35:0] btn_b;
  logic        jclk_c, load_c, fv_c, chg_c, data_c;
  logic [15:0] btn_c;

  logic [15:0] pat_a = 16'hFFFF;
  logic [35:0] pat_b = 36'hF_FFFF_FFFF;
  logic [15:0] pat_c = 16'h0000;
  logic [15:0] sh_a = '1;
  logic [35:0] sh_b = '1;
  logic [15:0] sh_c = '1;
  logic        pj_a = 1'b0, pj_b = 1'b0, pj_c = 1'b0;

  joy_serial_scanner #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(8), .CLK_DIV_LOG2(2),
                       .DEBOUNCE_FRAMES(2), .INVERT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en_a), .joy_data(data_a),
    .joy_clk(jclk_a), .joy_load_n(load_a), .buttons(btn_a),
    .frame_valid(fv_a), .changed(chg_a));

  joy_serial_scanner #(.NUM_PLAYERS(3), .BITS_PER_PLAYER(12), .CLK_DIV_LOG2(2),
                       .DEBOUNCE_FRAMES(1), .INVERT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en_b), .joy_data(data_b),
    .joy_clk(jclk_b), .joy_load_n(load_b), .buttons(btn_b),
    .frame_valid(fv_b), .changed(chg_b));

  joy_serial_scanner #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(8), .CLK_DIV_LOG2(2),
                       .DEBOUNCE_FRAMES(1), .INVERT(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en_c), .joy_data(data_c),
    .joy_clk(jclk_c), .joy_load_n(load_c), .buttons(btn_c),
    .frame_valid(fv_c), .changed(chg_c));

  // 74HC165 chain: parallel load while load_n is low, shift on rising joy_clk.
  always @(posedge clk) begin
    pj_a <= jclk_a;
    if (!load_a) sh_a <= pat_a;
    else if (jclk_a && !pj_a) sh_a <= sh_a >> 1;
    pj_b <= jclk_b;
    if (!load_b) sh_b <= pat_b;
    else if (jclk_b && !pj_b) sh_b <= sh_b >> 1;
    pj_c <= jclk_c;
    if (!load_c) sh_c <= pat_c;
    else if (jclk_c && !pj_c) sh_c <= sh_c >> 1;
  end
  assign data_a = sh_a[0];
  assign data_b = sh_b[0];
  assign data_c = sh_c[0];

  int cyc = 0;
  int nchg_a = 0, nfv_a = 0, nleave_a = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (chg_a) nchg_a <= nchg_a + 1;
    if (fv_a) nfv_a <= nfv_a + 1;
    if (btn_a != 16'hFFFF) nleave_a <= nleave_a + 1;
  end

  int total = 0, bad = 0;
  int rel_cyc = 0, fv_cyc = 0;
  logic [35:0] m_last [3];
  logic [35:0] m_btn  [3];
  int          m_cnt  [3];

  initial begin
    #5ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic get_fv(input int w);
    case (w) 0: return fv_a; 1: return fv_b; default: return fv_c; endcase
  endfunction
  function automatic logic get_chg(input int w);
    case (w) 0: return chg_a; 1: return chg_b; default: return chg_c; endcase
  endfunction
  function automatic logic get_load(input int w);
    case (w) 0: return load_a; 1: return load_b; default: return load_c; endcase
  endfunction
  function automatic logic get_jclk(input int w);
    case (w) 0: return jclk_a; 1: return jclk_b; default: return jclk_c; endcase
  endfunction
  function automatic logic [35:0] get_btn(input int w);
    case (w)
      0:       return {20'b0, btn_a};
      1:       return btn_b;
      default: return {20'b0, btn_c};
    endcase
  endfunction
  function automatic logic [35:0] ones(input int w);
    return (w == 1) ? 36'hF_FFFF_FFFF : 36'h0_0000_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fv(input int w, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (get_fv(w) === 1'b1) begin
        fv_cyc = cyc;
        return;
      end
    end
    total++;
    bad++;
    $error("FAIL %s_timeout observed=no_frame_valid expected=frame_valid within %0d", tag, budget);
  endtask

  // Present a pattern on the chain, wait for the frame that carries it and
  // compare against the debounce model.
  task automatic frame(input int w, input logic [35:0] pat, input string tag);
    logic [35:0] fw;
    logic        ec;
    int          deb;
    deb = (w == 0) ? 2 : 1;
    case (w)
      0:       pat_a = pat[15:0];
      1:       pat_b = pat;
      default: pat_c = pat[15:0];
    endcase
    wait_fv(w, 600, tag);
    fw = pat & ones(w);
    if (w == 2) fw = fw ^ ones(w);
    if (fw == m_last[w]) m_cnt[w] = (m_cnt[w] >= deb) ? deb : m_cnt[w] + 1;
    else                 m_cnt[w] = 1;
    m_last[w] = fw;
    ec = 1'b0;
    if (m_cnt[w] == deb && fw != m_btn[w]) begin
      m_btn[w] = fw;
      ec = 1'b1;
    end
    chk({tag, "_btn"}, 64'(get_btn(w)), 64'(m_btn[w]));
    chk({tag, "_chg"}, 64'(get_chg(w)), 64'(ec));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("%s_btn%0d", tag, w), 64'(get_btn(w)), 64'(ones(w)));
      chk($sformatf("%s_load%0d", tag, w), 64'(get_load(w)), 64'd0);
      chk($sformatf("%s_fv%0d", tag, w), 64'(get_fv(w)), 64'd0);
      chk($sformatf("%s_chg%0d", tag, w), 64'(get_chg(w)), 64'd0);
      chk($sformatf("%s_jclk%0d", tag, w), 64'(get_jclk(w)), 64'd0);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;
    for (int w = 0; w < 3; w++) begin
      m_last[w] = ones(w);
      m_btn[w]  = ones(w);
      m_cnt[w]  = 0;
    end
  endtask

  initial begin
    int t, n0, nl;
    logic [35:0] p;
    int reps;

    // Reset values and first-frame timing
    do_reset("rst0");
    frame(0, 36'hFFFF, "a_idle0");
    chk("a_first_fv_latency", 64'(fv_cyc - rel_cyc), 64'd61);
    t = fv_cyc;
    frame(0, 36'hFFFF, "a_idle1");
    chk("a_fv_period", 64'(fv_cyc - t), 64'd64);
    chk("a_jclk_low", 64'(jclk_a), 64'd0);
    @(negedge clk);
    chk("a_jclk_high", 64'(jclk_a), 64'd1);

    // Debounce: one press needs two identical frames
    n0 = nchg_a;
    frame(0, 36'hFF7F, "a_deb1");
    frame(0, 36'hFF7F, "a_deb2");
    frame(0, 36'hFF7F, "a_deb3");
    @(posedge clk); #1;
    chk("a_deb_nchg", 64'(nchg_a - n0), 64'd1);

    // Glitch rejection
    frame(0, 36'hFFFF, "a_rel1");
    frame(0, 36'hFFFF, "a_rel2");
    @(posedge clk); #1;
    n0 = nchg_a;
    nl = nleave_a;
    frame(0, 36'hF7FF, "a_glitch");
    frame(0, 36'hFFFF, "a_post1");
    frame(0, 36'hFFFF, "a_post2");
    @(posedge clk); #1;
    chk("a_glitch_nchg", 64'(nchg_a - n0), 64'd0);
    chk("a_glitch_leave", 64'(nleave_a - nl), 64'd0);

    // Random patterns held for a random number of frames
    for (int r = 0; r < 8; r++) begin
      p = 36'($urandom) & 36'hFFFF;
      reps = $urandom_range(1, 3);
      for (int k = 0; k < reps; k++) frame(0, p, $sformatf("a_rand%0d_%0d", r, k));
    end

    // scan_en drop mid-frame: frame completes, then scanning halts
    frame(0, 36'h5AA5, "a_se0");
    frame(0, 36'h5AA5, "a_se1");
    t = fv_cyc;
    repeat (22) @(negedge clk);
    scan_en_a = 1'b0;
    frame(0, 36'h5AA5, "a_se_finish");
    chk("a_se_finish_period", 64'(fv_cyc - t), 64'd64);
    @(negedge clk);
    n0 = nfv_a;
    nl = 0;
    repeat (100) begin
      @(negedge clk);
      if (load_a !== 1'b0) nl++;
    end
    chk("a_halt_load_n_low", 64'(nl), 64'd0);
    chk("a_halt_no_fv", 64'(nfv_a - n0), 64'd0);
    chk("a_halt_btn", 64'(btn_a), 64'(m_btn[0]));
    scan_en_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (load_a === 1'b1) break;
    end
    chk("a_resume_load_n", 64'(load_a), 64'd1);
    t = cyc;
    frame(0, 36'h5AA5, "a_resume");
    chk("a_resume_latency", 64'(fv_cyc - t), 64'd60);

    // Reset in the middle of a frame
    frame(0, 36'h1234, "a_pre0");
    frame(0, 36'h1234, "a_pre1");
    repeat (30) @(negedge clk);
    do_reset("rst_mid");
    frame(0, 36'h1234, "a_after_rst0");
    chk("a_rst_first_fv_latency", 64'(fv_cyc - rel_cyc), 64'd61);
    frame(0, 36'h1234, "a_after_rst1");

    // Bit ordering on a 3x12 chain with walking zero
    pat_b = 36'hF_FFFF_FFFF;
    do_reset("rst_b");
    frame(1, 36'hF_FFFF_FFFF, "b_idle");
    chk("b_first_fv_latency", 64'(fv_cyc - rel_cyc), 64'd141);
    t = fv_cyc;
    for (int k = 0; k < 36; k++) begin
      p = ~(36'd1 << k);
      frame(1, p, $sformatf("b_walk%0d", k));
      if (k == 0) chk("b_fv_period", 64'(fv_cyc - t), 64'd144);
    end

    // Inverted sampling
    pat_c = 16'h0000;
    do_reset("rst_c");
    frame(2, 36'h0000, "c_zero");
    frame(2, 36'h0008, "c_bit3");
    chk("c_bit3_low", 64'(btn_c[3]), 64'd0);
    for (int r = 0; r < 4; r++) begin
      p = 36'($urandom) & 36'hFFFF;
      frame(2, p, $sformatf("c_rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/joy_serial_scanner.md
Name: joy_serial_scanner

Overview:
- Parametrised serial joystick/button scanner for boards that chain one or more 74HC165-style PISO shift registers.
- Generates the shift clock and the parallel-load strobe, then deserialises NUM_PLAYERS × BITS_PER_PLAYER bits per frame.
- Debounces each frame over a configurable number of identical frames and presents a stable, active-low button vector to the core input logic.
- Adds a frame-valid strobe, a change strobe and a scan-enable gate.

Parameters:
NUM_PLAYERS, 2, number of controller ports in the chain (≥1)
BITS_PER_PLAYER, 8, bits per port (≥1); TOTAL = NUM_PLAYERS*BITS_PER_PLAYER, must be ≥2
CLK_DIV_LOG2, 8, prescaler width; one shift tick every 2^CLK_DIV_LOG2 clk cycles (≥1)
DEBOUNCE_FRAMES, 2, identical consecutive frames required before buttons update (≥1; 1 = no debounce)
INVERT, 0, 1 = XOR every sampled bit with 1 (for active-high hardware)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
scan_en  in  1  1 = scanning runs; 0 = stop at next frame boundary
joy_data  in  1  serial data from the shift-register chain
joy_clk  out  1  shift clock to the chain
joy_load_n  out  1  parallel-load strobe, active low
buttons  out  TOTAL  debounced button vector, active low (1 = released)
frame_valid  out  1  one-clk pulse per completed frame
changed  out  1  one-clk pulse when buttons changes value

Behaviour:
- Reset is asynchronous active-low on every register. Reset values:
  - prescaler = 0, bit_idx = 0, stable_cnt = 0
  - shadow = all 1, last_frame = all 1, buttons = all 1
  - frame_valid = 0, changed = 0
  - joy_clk = 0, joy_load_n = 0
- Prescaler: CLK_DIV_LOG2-bit free-running up-counter; wraps.
  - joy_clk = prescaler MSB.
  - tick = (prescaler == 0).
  - The first tick occurs on the first clk edge after reset release.
- joy_load_n = 0 exactly while bit_idx == 0, otherwise 1 (combinational from the registered bit_idx).
- On each tick, with bit_idx < TOTAL:
  - shadow[bit_idx] <= joy_data ^ INVERT.
  - bit_idx increments; on reaching TOTAL-1 it wraps to 0.
  - bit_idx width = clog2(TOTAL).
- Frame completes on the tick where bit_idx == TOTAL-1:
  - frame_word = {sampled bit, shadow[TOTAL-2:0]}.
  - Same edge: frame_valid <= 1 for exactly one clk.
  - If frame_word == last_frame: stable_cnt <= min(stable_cnt+1, DEBOUNCE_FRAMES). Otherwise stable_cnt <= 1.
  - last_frame <= frame_word.
  - If the updated stable_cnt == DEBOUNCE_FRAMES and frame_word != buttons: buttons <= frame_word and changed <= 1 for one clk.
  - Timing: buttons, frame_valid and changed all update on the same edge, so the result is visible one cycle after the final sample.
- Bit mapping: buttons[p*BITS_PER_PLAYER + b] = player p, bit b. Sample order = ascending index.
  - For BITS_PER_PLAYER = 8: b7 up, b6 down, b5 left, b4 right, b3 fire1, b2 fire2, b1 fire3, b0 start.
- scan_en:
  - Sampled only when bit_idx == 0 on a tick.
  - If 0, bit_idx holds at 0 (load asserted, no sampling); buttons hold.
  - A frame in progress always completes. The prescaler keeps running regardless.
- Debounce saturates: a constant input yields no further changed pulses.
- Reset mid-frame discards the partial frame; outputs return to reset values immediately.
- Simultaneous frame completion and scan_en falling: the frame commits normally, then scanning halts.

Test Plan:
1. Reset and idle (bench uses CLK_DIV_LOG2=2, defaults otherwise):
   - Assert reset_n = 0 mid-frame -> buttons = 16'hFFFF, joy_load_n = 0, frame_valid = 0 immediately.
   - After release, first sample on the first edge; frame_valid period = 64 clk.
2. Debounce:
   - Serial model drives 16'hFF7F (player 1 up pressed) continuously.
   - Frame 1 -> buttons stays FFFF, no changed pulse.
   - Frame 2 -> buttons = FF7F, one changed pulse.
   - Frame 3 -> no changed pulse.
3. Glitch rejection:
   - One frame of 16'hF7FF inside steady FFFF -> buttons never leaves FFFF; changed never asserts.
4. Bit ordering (NUM_PLAYERS=3, BITS_PER_PLAYER=12, DEBOUNCE_FRAMES=1):
   - Walking-zero pattern -> each bit k appears at buttons[k] after one frame; frame length = 36 ticks.
5. scan_en:
   - Deassert scan_en at bit_idx = 5 -> frame finishes at bit 15.
   - Then joy_load_n stays 0 and frame_valid stops.
   - Reassert -> sampling resumes at bit 0 on the next tick.
6. INVERT=1, DEBOUNCE_FRAMES=1:
   - Drive all-zero serial data -> buttons = all 1.
   - Drive bit 3 = 1 -> buttons[3] = 0 after one frame.
